// File: rtl/spi_register_pkg.sv
// Shared types and constants for the SPI register router: FSM states, opcode map, error bytes.
package spi_register_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OPCODE = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_BAD_OP = 2'd3
    } state_t;

    localparam logic [7:0] OPCODE_CHIP_ID = 8'hDB;
    localparam logic [7:0] OPCODE_REG1    = 8'hDC;
    localparam logic [7:0] OPCODE_REG2    = 8'hDD;
    localparam logic [7:0] OPCODE_REG3    = 8'hDE;

    localparam logic [7:0] IDLE_BYTE_DEF    = 8'h00;
    localparam logic [7:0] BAD_OP_BYTE_DEF  = 8'hFF;
    localparam logic [7:0] TIMEOUT_BYTE_DEF = 8'hEE;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? 4'hF : v + 4'd1;
    endfunction

endpackage

// File: rtl/spi_opcode_decoder.sv
// Opcode decoder: compares one byte against the opcode table, giving a one-hot register select and a hit flag.
// Latency: purely combinational.
// Backpressure: none, no state.
module spi_opcode_decoder
    import spi_register_pkg::*;
#(
    parameter int                       NUM_REGS = 4,
    parameter logic [NUM_REGS-1:0][7:0] OPCODES  = {OPCODE_REG3, OPCODE_REG2, OPCODE_REG1, OPCODE_CHIP_ID}
) (
    input  logic [7:0]          opcode_dat,
    output logic [NUM_REGS-1:0] onehot,
    output logic                hit
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            onehot[i] = (opcode_dat == OPCODES[i]);
        end
        hit = |onehot;
    end

endmodule

// File: rtl/spi_register_router.sv
// SPI transaction router: first byte of a CS window selects a register, later bytes become operands, responses go to tx.
// Latency: 1 cycle from rx_valid / reg_data_valid to the registered outputs.
// Backpressure: none; strobes are consumed on arrival, silent responders are cut off after TIMEOUT_CYCLES.
module spi_register_router
    import spi_register_pkg::*;
#(
    parameter int                       NUM_REGS       = 4,
    parameter logic [NUM_REGS-1:0][7:0] OPCODES        = {OPCODE_REG3, OPCODE_REG2, OPCODE_REG1, OPCODE_CHIP_ID},
    parameter int                       TIMEOUT_CYCLES = 16,
    parameter logic [7:0]               IDLE_BYTE      = IDLE_BYTE_DEF,
    parameter logic [7:0]               BAD_OP_BYTE    = BAD_OP_BYTE_DEF,
    parameter logic [7:0]               TIMEOUT_BYTE   = TIMEOUT_BYTE_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cs_active,
    input  logic [7:0]            rx_byte,
    input  logic                  rx_valid,
    output logic [NUM_REGS-1:0]   enable,
    output logic [7:0]            operand,
    output logic                  operand_valid,
    output logic [3:0]            operand_index,
    input  logic [NUM_REGS*8-1:0] reg_data,
    input  logic [NUM_REGS-1:0]   reg_data_valid,
    output logic [7:0]            tx_byte,
    output logic                  bad_opcode,
    output logic                  timeout
);

    state_t                state_q, state_d;
    logic [NUM_REGS-1:0]   enable_q, enable_d;
    logic [7:0]            operand_q, operand_d;
    logic                  operand_valid_q, operand_valid_d;
    logic [3:0]            operand_index_q, operand_index_d;
    logic [3:0]            op_cnt_q, op_cnt_d;
    logic [7:0]            tx_byte_q, tx_byte_d;
    logic                  bad_opcode_q, bad_opcode_d;
    logic                  timeout_q, timeout_d;
    logic [4:0]            tmo_cnt_q, tmo_cnt_d;
    logic                  resp_seen_q, resp_seen_d;
    logic                  cs_block_q, cs_block_d;

    logic [NUM_REGS-1:0]   dec_onehot;
    logic                  dec_hit;
    logic                  sel_vld;
    logic [7:0]            sel_dat;

    spi_opcode_decoder #(
        .NUM_REGS (NUM_REGS),
        .OPCODES  (OPCODES)
    ) u_decoder (
        .opcode_dat (rx_byte),
        .onehot     (dec_onehot),
        .hit        (dec_hit)
    );

    // Only the enabled responder can drive tx; valids on other indices fall out here.
    always_comb begin
        sel_vld = 1'b0;
        sel_dat = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (enable_q[i] && reg_data_valid[i]) begin
                sel_vld = 1'b1;
                sel_dat = sel_dat | reg_data[i*8 +: 8];
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        enable_d        = enable_q;
        operand_d       = operand_q;
        operand_valid_d = 1'b0;
        operand_index_d = operand_index_q;
        op_cnt_d        = op_cnt_q;
        tx_byte_d       = tx_byte_q;
        bad_opcode_d    = bad_opcode_q;
        timeout_d       = timeout_q;
        tmo_cnt_d       = tmo_cnt_q;
        resp_seen_d     = resp_seen_q;
        cs_block_d      = cs_block_q;

        if (!cs_active) begin
            state_d         = ST_IDLE;
            enable_d        = '0;
            operand_index_d = '0;
            op_cnt_d        = '0;
            tx_byte_d       = IDLE_BYTE;
            bad_opcode_d    = 1'b0;
            timeout_d       = 1'b0;
            tmo_cnt_d       = '0;
            resp_seen_d     = 1'b0;
            cs_block_d      = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // After a reset inside a window, wait for CS to drop before decoding again.
                    if (!cs_block_q) state_d = ST_OPCODE;
                end
                ST_OPCODE: begin
                    if (rx_valid) begin
                        if (dec_hit) begin
                            enable_d    = dec_onehot;
                            tmo_cnt_d   = '0;
                            resp_seen_d = 1'b0;
                            state_d     = ST_ACTIVE;
                        end else begin
                            bad_opcode_d = 1'b1;
                            tx_byte_d    = BAD_OP_BYTE;
                            state_d      = ST_BAD_OP;
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (rx_valid) begin
                        operand_d       = rx_byte;
                        operand_valid_d = 1'b1;
                        operand_index_d = op_cnt_q;
                        op_cnt_d        = sat_inc4(op_cnt_q);
                    end
                    if (sel_vld) begin
                        tx_byte_d   = sel_dat;
                        resp_seen_d = 1'b1;
                    end else if (!resp_seen_q && !timeout_q) begin
                        if (tmo_cnt_q == 5'(TIMEOUT_CYCLES - 1)) begin
                            timeout_d = 1'b1;
                            tx_byte_d = TIMEOUT_BYTE;
                        end else begin
                            tmo_cnt_d = tmo_cnt_q + 5'd1;
                        end
                    end
                end
                ST_BAD_OP: begin
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            enable_q        <= '0;
            operand_q       <= '0;
            operand_valid_q <= 1'b0;
            operand_index_q <= '0;
            op_cnt_q        <= '0;
            tx_byte_q       <= IDLE_BYTE;
            bad_opcode_q    <= 1'b0;
            timeout_q       <= 1'b0;
            tmo_cnt_q       <= '0;
            resp_seen_q     <= 1'b0;
            cs_block_q      <= 1'b1;
        end else begin
            state_q         <= state_d;
            enable_q        <= enable_d;
            operand_q       <= operand_d;
            operand_valid_q <= operand_valid_d;
            operand_index_q <= operand_index_d;
            op_cnt_q        <= op_cnt_d;
            tx_byte_q       <= tx_byte_d;
            bad_opcode_q    <= bad_opcode_d;
            timeout_q       <= timeout_d;
            tmo_cnt_q       <= tmo_cnt_d;
            resp_seen_q     <= resp_seen_d;
            cs_block_q      <= cs_block_d;
        end
    end

    assign enable        = enable_q;
    assign operand       = operand_q;
    assign operand_valid = operand_valid_q;
    assign operand_index = operand_index_q;
    assign tx_byte       = tx_byte_q;
    assign bad_opcode    = bad_opcode_q;
    assign timeout       = timeout_q;

endmodule
